// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues single-outstanding word reads and registers the result.
// Optional macro FETCH_ILLEGAL_CHECK_EN enables the registered unsupported-opcode flag.
module fetch_unit #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                stall,
  output logic                instr_valid,
  output logic [31:0]         instr,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic [6:0]          opcode,
  output logic                illegal_op
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t              state_reg, state_next;
  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  logic                squash_reg, squash_next;
  logic                valid_reg, valid_next;
  logic [31:0]         instr_reg, instr_next;
  logic [PC_WIDTH-1:0] instr_pc_reg, instr_pc_next;
  logic                accept;
  logic                load;
  logic                unused_target_bits;

  // Low target bits are forced to zero, so they are deliberately dropped.
  assign unused_target_bits = ^branch_target[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      pc_reg       <= {RESET_PC[PC_WIDTH-1:2], 2'b00};
      squash_reg   <= 1'b0;
      valid_reg    <= 1'b0;
      instr_reg    <= '0;
      instr_pc_reg <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      squash_reg   <= squash_next;
      valid_reg    <= valid_next;
      instr_reg    <= instr_next;
      instr_pc_reg <= instr_pc_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    squash_next   = squash_reg;
    valid_next    = valid_reg;
    instr_next    = instr_reg;
    instr_pc_next = instr_pc_reg;
    load          = 1'b0;

    // Holding back the request while the slot is stalled keeps the slot free for the response.
    imem_req = (state_reg == S_REQ) && !(valid_reg && stall);
    accept   = imem_req && imem_ready;

    if (valid_reg && !stall) begin
      valid_next = 1'b0;
    end

    case (state_reg)
      S_IDLE: state_next = S_REQ;
      S_REQ: begin
        if (accept) begin
          state_next  = S_WAIT;
          squash_next = branch_taken;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_next  = S_REQ;
          squash_next = 1'b0;
          load        = !squash_reg && !branch_taken;
        end else if (branch_taken) begin
          squash_next = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (load) begin
      instr_next    = imem_rdata;
      instr_pc_next = pc_reg;
      valid_next    = 1'b1;
      pc_next       = pc_reg + PC_WIDTH'(4);
    end

    // A redirect overrides both the stall hold and any same-cycle load.
    if (branch_taken) begin
      pc_next    = {branch_target[PC_WIDTH-1:2], 2'b00};
      valid_next = 1'b0;
    end
  end

  assign imem_addr   = {pc_reg[PC_WIDTH-1:2], 2'b00};
  assign instr_valid = valid_reg;
  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;
  assign opcode      = instr_reg[6:0];

`ifdef FETCH_ILLEGAL_CHECK_EN
  logic illegal_reg, illegal_next;

  function automatic logic op_unsupported(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  always_comb begin
    illegal_next = illegal_reg;
    if (load) begin
      illegal_next = op_unsupported(imem_rdata[6:0]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal_reg <= 1'b0;
    end else begin
      illegal_reg <= illegal_next;
    end
  end

  assign illegal_op = valid_reg && illegal_reg;
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a per-cycle memory responder pushes expected instructions,
// which are popped and compared when the DUT presents a new instruction.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        stall = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic        illegal_op;

  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        imem_ready2 = 1'b1;
  logic        imem_rvalid2 = 1'b0;
  logic [31:0] imem_rdata2 = 32'h13;
  logic        branch_taken2 = 1'b0;
  logic [31:0] branch_target2 = '0;
  logic        stall2 = 1'b0;
  logic        instr_valid2;
  logic [31:0] instr2;
  logic [31:0] instr_pc2;
  logic [6:0]  opcode2;
  logic        illegal_op2;

  always #5 clk = ~clk;

  fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h00000000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .opcode(opcode), .illegal_op(illegal_op)
  );

  fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'hFFFFFFFC)) dut_top (
    .clk(clk), .reset(reset),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(imem_ready2),
    .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
    .branch_taken(branch_taken2), .branch_target(branch_target2), .stall(stall2),
    .instr_valid(instr_valid2), .instr(instr2), .instr_pc(instr_pc2),
    .opcode(opcode2), .illegal_op(illegal_op2)
  );

  int checks = 0;
  int errors = 0;
  int tcount = 0;
  int seen_count = 0;

  exp_t        sb_q[$];
  logic [31:0] acc_q[$];
  int          acc_tick[$];
  logic [31:0] acc2_q[$];

  // stimulus controls for the next cycle
  logic        t_stall = 1'b0;
  logic        t_branch = 1'b0;
  logic [31:0] t_target = '0;
  logic        t_ready = 1'b1;
  int          t_lat = 0;
  logic [6:0]  t_op = 7'h33;
  logic [24:0] t_hi = '0;

  // memory responder state
  logic        resp_busy = 1'b0;
  int          resp_wait = 0;
  logic [31:0] resp_addr = '0;
  logic [31:0] resp_data = '0;
  logic        resp_killed = 1'b0;
  logic        resp2_busy = 1'b0;

  logic        prev_valid = 1'b0;
  logic        last_req = 1'b0;
  logic [31:0] last_addr = '0;
  logic        accepted = 1'b0;
  logic [31:0] last_seen_pc = '0;

  function automatic logic expect_illegal(input logic [6:0] op);
`ifdef FETCH_ILLEGAL_CHECK_EN
    return !(op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
             op == 7'b0100011 || op == 7'b1100011);
`else
    return (op == 7'h00) && (op != 7'h00);
`endif
  endfunction

  // One clock cycle: sample/score outputs, drive inputs, then observe the request handshake.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    tcount++;
    if (reset && instr_valid && (!prev_valid || !stall)) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got instr_pc=%h instr=%h, required no instruction", instr_pc, instr);
      end else begin
        e = sb_q.pop_front();
        if (instr !== e.data || instr_pc !== e.pc || opcode !== e.data[6:0] ||
            illegal_op !== expect_illegal(e.data[6:0])) begin
          errors++;
          $display("FAIL sb_instr: got pc=%h instr=%h op=%b ill=%b, required pc=%h instr=%h op=%b ill=%b",
                   instr_pc, instr, opcode, illegal_op, e.pc, e.data, e.data[6:0],
                   expect_illegal(e.data[6:0]));
        end
        last_seen_pc = instr_pc;
        seen_count++;
      end
    end
    prev_valid = instr_valid;

    stall         = t_stall;
    branch_taken  = t_branch;
    branch_target = t_target;
    imem_ready    = t_ready;
    imem_rvalid   = 1'b0;
    if (resp_busy) begin
      if (resp_wait == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = resp_data;
        resp_busy   = 1'b0;
        if (!resp_killed && !t_branch && reset) sb_q.push_back('{pc: resp_addr, data: resp_data});
      end else begin
        resp_wait--;
        if (t_branch) resp_killed = 1'b1;
      end
    end
    imem_rvalid2 = resp2_busy;
    resp2_busy   = 1'b0;
    #1;
    last_req  = imem_req;
    last_addr = imem_addr;
    accepted  = 1'b0;
    if (reset && imem_req && imem_ready) begin
      accepted    = 1'b1;
      resp_busy   = 1'b1;
      resp_wait   = t_lat;
      resp_addr   = imem_addr;
      resp_data   = {t_hi, t_op};
      resp_killed = t_branch;
      acc_q.push_back(imem_addr);
      acc_tick.push_back(tcount);
    end
    if (reset && imem_req2 && imem_ready2) begin
      resp2_busy = 1'b1;
      acc2_q.push_back(imem_addr2);
    end
  endtask

  task automatic wait_accept(input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!accepted && n < 30);
    if (!accepted) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no accepted request, required one within 30 cycles", name);
    end
  endtask

  task automatic wait_seen(input string name, input logic [6:0] op);
    int n = 0;
    int base;
    do begin
      base = seen_count;
      tick();
      n++;
    end while (!(seen_count != base && opcode == op) && n < 30);
    if (!(seen_count != base && opcode == op)) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no instruction with opcode %b, required one within 30 cycles", name, op);
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got req=%b valid=%b, required 0 0", imem_req, instr_valid);
    end
    checks++;
    if (instr !== 32'h0 || instr_pc !== 32'h0) begin
      errors++; $display("FAIL reset_regs: got instr=%h pc=%h, required 0 0", instr, instr_pc);
    end
    checks++;
    if (opcode !== 7'h0 || illegal_op !== 1'b0) begin
      errors++; $display("FAIL reset_op: got opcode=%b ill=%b, required 0 0", opcode, illegal_op);
    end
    checks++;
    if (imem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_addr: got %h, required 00000000", imem_addr);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    t_op = 7'h33; t_hi = '0; t_ready = 1'b1; t_lat = 0;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (acc_q.size() < 3) begin
      errors++; $display("FAIL basic_count: got %0d requests, required 3", acc_q.size());
    end else begin
      checks++;
      if (acc_q[0] !== 32'h0 || acc_q[1] !== 32'h4 || acc_q[2] !== 32'h8) begin
        errors++; $display("FAIL basic_addr: got %h %h %h, required 0 4 8", acc_q[0], acc_q[1], acc_q[2]);
      end
      checks++;
      if (acc_tick[1] - acc_tick[0] != 2 || acc_tick[2] - acc_tick[1] != 2) begin
        errors++; $display("FAIL basic_rate: got spacing %0d %0d, required 2 2",
                           acc_tick[1] - acc_tick[0], acc_tick[2] - acc_tick[1]);
      end
    end
    checks++;
    if (seen_count != 2 || last_seen_pc !== 32'h4) begin
      errors++; $display("FAIL basic_instr: got %0d instrs last pc %h, required 2 last pc 4", seen_count, last_seen_pc);
    end
  endtask

  task automatic test_reset_pc();
    checks++;
    if (acc2_q.size() < 2) begin
      errors++; $display("FAIL resetpc_count: got %0d requests, required 2", acc2_q.size());
    end else begin
      checks++;
      if (acc2_q[0] !== 32'hFFFFFFFC) begin
        errors++; $display("FAIL resetpc_first: got %h, required fffffffc", acc2_q[0]);
      end
      checks++;
      if (acc2_q[1] !== 32'h0) begin
        errors++; $display("FAIL resetpc_wrap: got %h, required 00000000", acc2_q[1]);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] snap_instr, snap_pc;
    int n = 0;
    t_stall = 1'b1;
    do begin
      tick();
      n++;
    end while (!instr_valid && n < 30);
    snap_instr = instr;
    snap_pc    = instr_pc;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      checks++;
      if (last_req !== 1'b0 || instr_valid !== 1'b1 || instr !== snap_instr || instr_pc !== snap_pc) begin
        errors++;
        $display("FAIL stall_hold%0d: got req=%b valid=%b instr=%h pc=%h, required 0 1 %h %h",
                 i, last_req, instr_valid, instr, instr_pc, snap_instr, snap_pc);
      end
    end
    t_stall = 1'b0;
    tick();
    checks++;
    if (!accepted || acc_q[$] !== snap_pc + 32'd4) begin
      errors++; $display("FAIL stall_resume: got accepted=%b addr=%h, required 1 %h", accepted, last_addr, snap_pc + 32'd4);
    end
  endtask

  task automatic test_branch(input string name, input int lat, input logic [31:0] target);
    t_lat = lat;
    wait_accept(name);
    t_branch = 1'b1;
    t_target = target;
    tick();
    t_branch = 1'b0;
    t_lat = 0;
    wait_accept(name);
    checks++;
    if (acc_q[$] !== target) begin
      errors++; $display("FAIL %s_addr: got %h, required %h", name, acc_q[$], target);
    end
    wait_seen(name, t_op);
    checks++;
    if (last_seen_pc !== target) begin
      errors++; $display("FAIL %s_pc: got %h, required %h", name, last_seen_pc, target);
    end
  endtask

  task automatic test_ready();
    logic [31:0] snap;
    int n = 0;
    t_ready = 1'b0;
    do begin
      tick();
      n++;
    end while (!last_req && n < 30);
    snap = last_addr;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (last_req !== 1'b1 || last_addr !== snap) begin
        errors++; $display("FAIL ready_hold%0d: got req=%b addr=%h, required 1 %h", i, last_req, last_addr, snap);
      end
    end
    t_ready = 1'b1;
    tick();
    checks++;
    if (!accepted || acc_q[$] !== snap) begin
      errors++; $display("FAIL ready_accept: got accepted=%b addr=%h, required 1 %h", accepted, last_addr, snap);
    end
  endtask

  task automatic test_illegal();
    t_hi = 25'h0ABCDE;
    t_op = 7'b1111111;
    wait_seen("illegal", t_op);
    checks++;
    if (illegal_op !== expect_illegal(7'b1111111)) begin
      errors++; $display("FAIL illegal_7f: got %b, required %b", illegal_op, expect_illegal(7'b1111111));
    end
    t_op = 7'b1100011;
    wait_seen("legal", t_op);
    checks++;
    if (illegal_op !== 1'b0) begin
      errors++; $display("FAIL illegal_branch_op: got %b, required 0", illegal_op);
    end
    t_op = 7'h33;
    t_hi = '0;
  endtask

  task automatic test_reset_midfetch();
    t_lat = 1;
    wait_accept("midreset");
    reset = 1'b0;
    resp_killed = 1'b1;
    sb_q.delete();
    #1;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr_pc !== 32'h0) begin
      errors++; $display("FAIL midreset_clear: got req=%b valid=%b pc=%h, required 0 0 0", imem_req, instr_valid, instr_pc);
    end
    #1;
    reset = 1'b1;
    t_lat = 0;
    wait_accept("midreset");
    checks++;
    if (acc_q[$] !== 32'h0) begin
      errors++; $display("FAIL midreset_addr: got %h, required 00000000", acc_q[$]);
    end
    wait_seen("midreset", t_op);
    checks++;
    if (last_seen_pc !== 32'h0) begin
      errors++; $display("FAIL midreset_pc: got %h, required 00000000", last_seen_pc);
    end
  endtask

  task automatic test_back_to_back();
    int base = seen_count;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (seen_count - base != 5) begin
      errors++; $display("FAIL b2b_count: got %0d instrs in 10 cycles, required 5", seen_count - base);
    end
    t_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL drain: got %0d undelivered responses, required 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_pc();
    test_stall();
    test_branch("branch_rvalid", 0, 32'h40);
    test_branch("branch_squash", 2, 32'h80);
    test_ready();
    test_illegal();
    test_reset_midfetch();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
